inst_fetch_unit: RTL

// - Instruction-side producer for the control decoder: holds the PC, fetches 32-bit words from

---
 rtl/inst_fetch_unit.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches words over a req/ack handshake to
// instruction memory and holds one instruction for the decoder behind valid/ready.
// A redirect that lands while a request is outstanding cannot cancel the request,
// so a kill flag marks the in-flight response as stale and forces a reissue.
module inst_fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halt,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [5:0]        op,
  output logic [5:0]        funct,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [CNT_W-1:0]  fetch_cnt
);

  localparam int unsigned INST_W = 32;
  localparam int unsigned FLD_W  = 6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              kill;

  logic [ADDR_W-1:0] redirect_target;
  logic [ADDR_W-1:0] seq_pc;
  logic              unused_redirect_lsbs;

  // Redirect targets are word aligned; the sequential successor wraps modulo 2^ADDR_W
  assign redirect_target      = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign seq_pc               = imem_addr + ADDR_W'(4);
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Fetch FSM with all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      kill       <= 1'b0;
      imem_req   <= 1'b0;
      imem_addr  <= RESET_PC;
      inst_valid <= 1'b0;
      inst       <= '0;
      op         <= '0;
      funct      <= '0;
      inst_pc    <= '0;
      fetch_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (redirect_valid) begin
            pc <= redirect_target;
            if (!halt) begin
              state     <= S_REQ;
              imem_req  <= 1'b1;
              imem_addr <= redirect_target;
            end
          end else if (!halt) begin
            state     <= S_REQ;
            imem_req  <= 1'b1;
            imem_addr <= pc;
          end
        end

        S_REQ: begin
          if (redirect_valid) begin
            // Address must stay stable until ack; a coincident ack is stale and reissued
            pc <= redirect_target;
            if (imem_ack) begin
              kill      <= 1'b0;
              imem_addr <= redirect_target;
            end else begin
              kill <= 1'b1;
            end
          end else if (imem_ack) begin
            if (kill) begin
              kill      <= 1'b0;
              imem_addr <= pc;
            end else begin
              state      <= S_VALID;
              imem_req   <= 1'b0;
              inst_valid <= 1'b1;
              inst       <= imem_rdata;
              op         <= imem_rdata[INST_W-1 -: FLD_W];
              funct      <= imem_rdata[FLD_W-1:0];
              inst_pc    <= imem_addr;
              pc         <= seq_pc;
            end
          end
        end

        S_VALID: begin
          if (redirect_valid) begin
            // Buffered instruction is on the wrong path: drop it without counting
            pc         <= redirect_target;
            inst_valid <= 1'b0;
            if (halt) begin
              state <= S_IDLE;
            end else begin
              state     <= S_REQ;
              imem_req  <= 1'b1;
              imem_addr <= redirect_target;
            end
          end else if (inst_ready) begin
            fetch_cnt  <= fetch_cnt + CNT_W'(1);
            inst_valid <= 1'b0;
            if (halt) begin
              state <= S_IDLE;
            end else begin
              state     <= S_REQ;
              imem_req  <= 1'b1;
              imem_addr <= pc;
            end
          end
        end

        default: begin
          state      <= S_IDLE;
          imem_req   <= 1'b0;
          inst_valid <= 1'b0;
          kill       <= 1'b0;
        end
      endcase
    end
  end

  // An outstanding request keeps its address until it is acknowledged
  a_req_stable: assert property (
    @(posedge clk) disable iff (!rst_n)
    (imem_req && !imem_ack) |=> (imem_req && $stable(imem_addr))
  );

  // Valid buffer and request are never live together
  a_req_valid_excl: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(imem_req && inst_valid)
  );

endmodule
